// File: rtl/bp_lce_req_arbiter.sv
// bp_lce_req_arbiter
// Round-robin arbiter that shares one LCE-to-CCE request link among several
// LCE request sources. The winning message is held in a one-entry output
// register until the network accepts it. Each source has an outstanding-request
// credit counter that caps its in-flight requests at credits_p. A complete that
// arrives while a counter is already zero sets a sticky error.

module bp_lce_req_arbiter #(
  parameter int num_src_p   = 2,
  parameter int msg_width_p = 64,
  parameter int credits_p   = 8,
  localparam int src_id_width_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1,
  localparam int cnt_width_lp    = $clog2(credits_p + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,

  input  logic [num_src_p*msg_width_p-1:0] src_msg_i,
  input  logic [num_src_p-1:0]             src_v_i,
  output logic [num_src_p-1:0]             src_yumi_o,
  input  logic [num_src_p-1:0]             src_complete_i,

  output logic [num_src_p-1:0]             credits_full_o,
  output logic [num_src_p-1:0]             credits_empty_o,

  output logic [msg_width_p-1:0]           lce_req_o,
  output logic [src_id_width_lp-1:0]       lce_req_src_o,
  output logic                             lce_req_v_o,
  input  logic                             lce_req_ready_i,

  output logic                             err_o
);

  // Output register state
  logic                       full_q;
  logic [msg_width_p-1:0]     msg_q;
  logic [src_id_width_lp-1:0] src_q;
  logic [src_id_width_lp-1:0] rr_ptr_q;
  logic [src_id_width_lp-1:0] rr_ptr_d;
  logic                       err_q;

  // Arbitration signals
  logic                       drain;
  logic                       can_capture;
  logic [num_src_p-1:0]       eligible;
  logic [num_src_p-1:0]       underflow;
  logic                       grant_v;
  logic [src_id_width_lp-1:0] grant_idx;
  logic [src_id_width_lp:0]   scan;
  logic [src_id_width_lp-1:0] scan_idx;

  assign drain       = full_q & lce_req_ready_i;
  assign can_capture = ~full_q | drain;

  // Round-robin scan from rr_ptr_q upward; reset also suppresses any yumi
  always_comb begin
    grant_v   = 1'b0;
    grant_idx = '0;
    scan      = '0;
    scan_idx  = '0;
    if (can_capture && reset_n_i) begin
      for (int k = 0; k < num_src_p; k++) begin
        scan = {1'b0, rr_ptr_q} + (src_id_width_lp+1)'(k);
        if (scan >= (src_id_width_lp+1)'(num_src_p)) begin
          scan = scan - (src_id_width_lp+1)'(num_src_p);
        end
        scan_idx = scan[src_id_width_lp-1:0];
        if (!grant_v && eligible[scan_idx]) begin
          grant_v   = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
  end

  // One-hot yumi for the granted source
  always_comb begin
    src_yumi_o = '0;
    for (int i = 0; i < num_src_p; i++) begin
      src_yumi_o[i] = grant_v && (grant_idx == src_id_width_lp'(i));
    end
  end

  // Pointer advances past the winner, wrapping at num_src_p
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_v) begin
      if (grant_idx == src_id_width_lp'(num_src_p - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx + src_id_width_lp'(1);
      end
    end
  end

  // Output register: capture on grant (replacing a draining message), clear on bare drain
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      full_q   <= 1'b0;
      msg_q    <= '0;
      src_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (grant_v) begin
        full_q <= 1'b1;
        msg_q  <= src_msg_i[grant_idx*msg_width_p +: msg_width_p];
        src_q  <= grant_idx;
      end else if (drain) begin
        full_q <= 1'b0;
      end
    end
  end

  // Sticky error on any credit underflow
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_q <= 1'b0;
    end else if (|underflow) begin
      err_q <= 1'b1;
    end
  end

  // Per-source credit counters
  for (genvar gi = 0; gi < num_src_p; gi++) begin : g_credit
    logic [cnt_width_lp-1:0] cnt_q;
    logic [cnt_width_lp-1:0] cnt_d;
    logic                    cfull_q;
    logic                    cempty_q;

    // Eligibility uses the pre-update count
    assign eligible[gi] = src_v_i[gi] && (cnt_q < cnt_width_lp'(credits_p));

    // Yumi adds a credit in use, complete returns one; both together cancel
    always_comb begin
      cnt_d         = cnt_q;
      underflow[gi] = src_complete_i[gi] && (cnt_q == '0);
      if (src_yumi_o[gi] && !src_complete_i[gi]) begin
        cnt_d = cnt_q + cnt_width_lp'(1);
      end else if (!src_yumi_o[gi] && src_complete_i[gi] && (cnt_q != '0)) begin
        cnt_d = cnt_q - cnt_width_lp'(1);
      end
    end

    // Counter and its registered full/empty flags
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        cnt_q    <= '0;
        cfull_q  <= 1'b0;
        cempty_q <= 1'b1;
      end else begin
        cnt_q    <= cnt_d;
        cfull_q  <= (cnt_d == cnt_width_lp'(credits_p));
        cempty_q <= (cnt_d == '0);
      end
    end

    assign credits_full_o[gi]  = cfull_q;
    assign credits_empty_o[gi] = cempty_q;
  end

  assign lce_req_v_o   = full_q;
  assign lce_req_o     = msg_q;
  assign lce_req_src_o = src_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_bp_lce_req_arbiter.sv
// Directed bench for bp_lce_req_arbiter with two sources and two credits each.
module tb_bp_lce_req_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] src_msg;
  logic [1:0]  src_v;
  logic [1:0]  src_yumi;
  logic [1:0]  src_complete;
  logic [1:0]  credits_full;
  logic [1:0]  credits_empty;
  logic [15:0] lce_req;
  logic        lce_req_src;
  logic        lce_req_v;
  logic        lce_req_ready;
  logic        err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bp_lce_req_arbiter #(
    .num_src_p  (2),
    .msg_width_p(16),
    .credits_p  (2)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .src_msg_i      (src_msg),
    .src_v_i        (src_v),
    .src_yumi_o     (src_yumi),
    .src_complete_i (src_complete),
    .credits_full_o (credits_full),
    .credits_empty_o(credits_empty),
    .lce_req_o      (lce_req),
    .lce_req_src_o  (lce_req_src),
    .lce_req_v_o    (lce_req_v),
    .lce_req_ready_i(lce_req_ready),
    .err_o          (err)
  );

  typedef struct {
    logic [1:0]  v;
    logic [15:0] m0;
    logic [15:0] m1;
    logic        rdy;
    logic [1:0]  cmp;
    logic [1:0]  ey;
    logic        elv;
    logic        chk_msg;
    logic [15:0] emsg;
    logic        esrc;
    logic [1:0]  ecf;
    logic [1:0]  ece;
    logic        eerr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] v, input logic [15:0] m0, input logic [15:0] m1,
                     input logic rdy, input logic [1:0] cmp, input logic [1:0] ey,
                     input logic elv, input logic chk_msg, input logic [15:0] emsg,
                     input logic esrc, input logic [1:0] ecf, input logic [1:0] ece,
                     input logic eerr);
    vec_t t;
    t.v = v; t.m0 = m0; t.m1 = m1; t.rdy = rdy; t.cmp = cmp;
    t.ey = ey; t.elv = elv; t.chk_msg = chk_msg; t.emsg = emsg; t.esrc = esrc;
    t.ecf = ecf; t.ece = ece; t.eerr = eerr;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    src_msg       = '0;
    src_v         = '0;
    src_complete  = '0;
    lce_req_ready = 1'b0;

    // Expected values are the state seen just before the vector's clock edge;
    // yumi is the combinational response to the vector's own inputs.
    //   v     m0        m1        rdy   cmp    yumi  lv    chk   msg       src   cfull  cempty err
    add(2'b00, 16'hA000, 16'hB000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 16'h0000, 1'b0, 2'b00, 2'b11, 1'b0);
    add(2'b11, 16'hA001, 16'hB001, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b00, 2'b11, 1'b0);
    add(2'b11, 16'hA002, 16'hB001, 1'b1, 2'b00, 2'b10, 1'b1, 1'b1, 16'hA001, 1'b0, 2'b00, 2'b10, 1'b0);
    add(2'b11, 16'hA002, 16'hB002, 1'b1, 2'b00, 2'b01, 1'b1, 1'b1, 16'hB001, 1'b1, 2'b00, 2'b00, 1'b0);
    add(2'b11, 16'hA003, 16'hB002, 1'b1, 2'b00, 2'b10, 1'b1, 1'b1, 16'hA002, 1'b0, 2'b01, 2'b00, 1'b0);
    // both sources out of credits
    add(2'b11, 16'hA003, 16'hB003, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 16'hB002, 1'b1, 2'b11, 2'b00, 1'b0);
    add(2'b11, 16'hA003, 16'hB003, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b11, 2'b00, 1'b0);
    // one returned credit -> exactly one more grant to source 0
    add(2'b11, 16'hA003, 16'hB003, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b10, 2'b00, 1'b0);
    // backpressure for 5 cycles, message held stable
    for (int i = 0; i < 5; i++) begin
      add(2'b11, 16'hA004, 16'hB003, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 16'hA003, 1'b0, 2'b11, 2'b00, 1'b0);
    end
    add(2'b11, 16'hA004, 16'hB003, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 16'hA003, 1'b0, 2'b11, 2'b00, 1'b0);
    add(2'b11, 16'hA004, 16'hB003, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b11, 2'b00, 1'b0);
    // complete and yumi together on source 1 at count 1
    add(2'b11, 16'hA004, 16'hB003, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b01, 2'b00, 1'b0);
    add(2'b00, 16'hA004, 16'hB004, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 16'hB003, 1'b1, 2'b01, 2'b00, 1'b0);
    // drain source 1 credits, then underflow
    add(2'b00, 16'hA004, 16'hB004, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b01, 2'b00, 1'b0);
    add(2'b00, 16'hA004, 16'hB004, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b01, 2'b10, 1'b0);
    add(2'b00, 16'hA004, 16'hB004, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b01, 2'b10, 1'b1);
    add(2'b10, 16'hA004, 16'hB004, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b01, 2'b10, 1'b1);
    add(2'b00, 16'hA004, 16'hB005, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 16'hB004, 1'b1, 2'b01, 2'b00, 1'b1);

    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      src_v         = vecs[i].v;
      src_msg       = {vecs[i].m1, vecs[i].m0};
      lce_req_ready = vecs[i].rdy;
      src_complete  = vecs[i].cmp;
      #1;
      check("yumi", i, 32'(src_yumi), 32'(vecs[i].ey));
      check("req_v", i, 32'(lce_req_v), 32'(vecs[i].elv));
      if (vecs[i].chk_msg) begin
        check("req_msg", i, 32'(lce_req), 32'(vecs[i].emsg));
        check("req_src", i, 32'(lce_req_src), 32'(vecs[i].esrc));
      end
      check("credits_full", i, 32'(credits_full), 32'(vecs[i].ecf));
      check("credits_empty", i, 32'(credits_empty), 32'(vecs[i].ece));
      check("err", i, 32'(err), 32'(vecs[i].eerr));
      $display("step %0d v=%b rdy=%b cmp=%b yumi=%b req_v=%b req=%h src=%0d cf=%b ce=%b err=%b",
               i, src_v, lce_req_ready, src_complete, src_yumi, lce_req_v, lce_req,
               lce_req_src, credits_full, credits_empty, err);
    end

    // Asynchronous reset while a message is held under backpressure
    @(negedge clk);
    src_v         = 2'b10;
    src_msg       = {16'hB005, 16'hA004};
    lce_req_ready = 1'b0;
    src_complete  = 2'b00;
    #1;
    check("rst_pre_yumi", 100, 32'(src_yumi), 32'h2);
    @(posedge clk);
    #1;
    check("rst_pre_v", 101, 32'(lce_req_v), 32'h1);
    check("rst_pre_msg", 101, 32'(lce_req), 32'hB005);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_v", 102, 32'(lce_req_v), 32'h0);
    check("rst_yumi", 102, 32'(src_yumi), 32'h0);
    check("rst_empty", 102, 32'(credits_empty), 32'h3);
    check("rst_full", 102, 32'(credits_full), 32'h0);
    check("rst_err", 102, 32'(err), 32'h0);
    check("rst_msg", 102, 32'(lce_req), 32'h0);
    check("rst_src", 102, 32'(lce_req_src), 32'h0);
    $display("reset mid-transfer: req_v=%b yumi=%b ce=%b cf=%b err=%b",
             lce_req_v, src_yumi, credits_empty, credits_full, err);
    @(negedge clk);
    src_v         = 2'b00;
    lce_req_ready = 1'b1;
    reset_n       = 1'b1;
    @(posedge clk);
    #1;
    check("rst_no_replay", 103, 32'(lce_req_v), 32'h0);
    check("rst_empty_after", 103, 32'(credits_empty), 32'h3);
    $display("after reset release: req_v=%b ce=%b", lce_req_v, credits_empty);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_lce_req_arbiter.md
# bp_lce_req_arbiter

Shares one LCE-to-CCE request link among `num_src_p` LCE request handlers, e.g. the I$ and D$ LCEs of a tile sharing one coherence-network request port. It arbitrates round-robin among valid sources and holds the winning message in a one-entry output register until the network accepts it. It keeps a per-source outstanding-request credit counter so that no source can exceed `credits_p` in-flight requests, and it raises a sticky error on credit underflow.

## Interface
- `num_src_p`, default 2: number of request sources; 1 to 8.
- `msg_width_p`, default `bp_bedrock_lce_req_msg_width_lp`: width of one request message.
- `credits_p`, default `coh_noc_max_credits_p`: maximum outstanding requests per source.
- `clk_i` input, 1: clock; all state is on the rising edge.
- `reset_n_i` input, 1: reset, asynchronous and active-low.
- `src_msg_i` input, `num_src_p*msg_width_p`: source i's message occupies bits [i*msg_width_p +: msg_width_p].
- `src_v_i` input, `num_src_p`: per-source valid. A source holds its message stable until it is yumi'd.
- `src_yumi_o` output, `num_src_p`: one-hot; the message was consumed this cycle.
- `src_complete_i` input, `num_src_p`: returns one credit for source i; 1-cycle pulse per completed request.
- `credits_full_o` output, `num_src_p`: source i count == `credits_p`.
- `credits_empty_o` output, `num_src_p`: source i count == 0.
- `lce_req_o` output, `msg_width_p`: held message.
- `lce_req_src_o` output, `BSG_SAFE_CLOG2(num_src_p)`: index of the source that owns `lce_req_o`.
- `lce_req_v_o` output, 1: valid/ready handshake to the network.
- `lce_req_ready_i` input, 1: network accepts when `lce_req_v_o & lce_req_ready_i`.
- `err_o` output, 1: sticky; set when a complete arrives while that source's count is 0.

## Operation
- **Output register**
  - `full_r` is 1 while a message is held. `lce_req_v_o` = `full_r`.
  - `drain` = `full_r & lce_req_ready_i`.
  - The register can capture when `~full_r | drain`, so back-to-back transfers run at 1 message per cycle.
- **Eligibility:** source i is eligible when `src_v_i[i] & (count_i < credits_p)`.
- **Arbitration**
  - When the register can capture and any source is eligible, grant the first eligible source scanning from `rr_ptr_r` upward with modular wrap.
  - On a grant: assert `src_yumi_o[g]`, load `src_msg_i` slice g into `lce_req_o` and g into `lce_req_src_o`, set `full_r`.
  - `rr_ptr_r` becomes (g+1) mod `num_src_p`.
  - With no grant, `rr_ptr_r` holds, and `full_r` clears if `drain`.
- **Credits**
  - Each source has a counter of width `BSG_WIDTH(credits_p)`.
  - It increments on that source's yumi and decrements on `src_complete_i[i]`.
  - Both in the same cycle leave the count unchanged.
  - A complete at count 0 leaves the count at 0 (saturates, no wrap) and sets `err_o`.
  - A yumi at count == `credits_p` is impossible by construction, since eligibility excludes it.
- **Message integrity:** the arbiter never alters message contents. Source identity travels only on `lce_req_src_o`.
- **Reset (`reset_n_i` = 0, asynchronous)**
  - `full_r`, `lce_req_v_o`, `src_yumi_o`, `err_o`, all counters, `lce_req_src_o` and `rr_ptr_r` go to 0.
  - `credits_empty_o` goes to all 1s; `credits_full_o` goes to 0.
  - `lce_req_o` goes to 0.
  - A held message is discarded. Reset mid-transfer drops it with no yumi replay.

## Timing
- `src_yumi_o` is combinational from `src_v_i`, `full_r`, `lce_req_ready_i`, `rr_ptr_r` and the counters. No path exists from `src_v_i` to `lce_req_v_o`.
- Latency: a message yumi'd in cycle t appears on `lce_req_o`/`lce_req_v_o` in cycle t+1.
- `lce_req_v_o` stays high and `lce_req_o` stays stable until accepted. `lce_req_v_o` never depends on `lce_req_ready_i`.
- Credit outputs and `err_o` are registered and reflect the counters at the current edge. `credits_full_o` rises the cycle after the yumi that fills the counter.
- Simultaneous drain and grant in the same cycle: the new message replaces the old one with no bubble.
- Simultaneous complete and yumi for the same source: the count is unchanged, and eligibility in that cycle uses the pre-update count.

## Test plan
- **Reset:** hold `reset_n_i` low mid-transfer with `full_r`=1 -> `lce_req_v_o`=0 immediately (asynchronous), `credits_empty_o`=2'b11, `err_o`=0.
- **Round-robin:** with `num_src_p`=2 and both sources valid continuously and `lce_req_ready_i`=1 -> grants alternate 0,1,0,1, one per cycle, and `lce_req_src_o` matches each message.
- **Backpressure:** `lce_req_ready_i`=0 for 5 cycles with a held message -> `lce_req_o` stable, no `src_yumi_o`, and exactly 1 transfer when ready rises.
- **Credit limit:** `credits_p`=2, source 0 always valid, no completes -> 2 yumis, then `credits_full_o[0]`=1 and no more grants to source 0 while source 1 is still served. One `src_complete_i[0]` pulse -> exactly one more grant.
- **Simultaneous:** complete and yumi on source 1 in the same cycle at count 1 -> count stays 1 and neither `credits_full_o` nor `credits_empty_o` changes.
- **Underflow:** `src_complete_i[1]` at count 0 -> `err_o`=1 from the next cycle and held until reset, count stays 0.
